// File: rtl/model_keys_in_if.sv
// model_keys_in_if: Avalon-MM slave bus bundle for the key/switch input port.
//   address    : word address, 2 bits
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from address
`timescale 1ns/1ps
interface model_keys_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/model_keys_in.sv
// model_keys_in: debounced push-button / switch input port with a
// PIO-compatible register map.
//   Each raw input bit is two-flop synchronised, debounced by its own counter
//   and exposed as a stable level. Qualifying edges of the debounced level
//   are latched in a sticky edge-capture register; irq is the OR of captured
//   edges gated by irqmask.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  : raw asynchronous external inputs, WIDTH bits
//   irq      : level interrupt, active high
// Register map (word addresses):
//   0 data (RO), 1 reads 0, 2 irqmask (RW), 3 edgecapture (R, W1C)
`timescale 1ns/1ps
module model_keys_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET        = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  model_keys_in_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned      CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] rise, fall, edge_hit, ec_clr;

  // Synchroniser and per-bit debounce. The counter only runs while the
  // synchronised bit disagrees with the debounced level, so any bounce back
  // restarts it from zero.
  always_comb begin
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge detection and register writes. A clear and a new edge in the same
  // cycle leave the bit set so no event is lost.
  always_comb begin
    rise  = deb_q & ~deb_prev_q;
    fall  = ~deb_q & deb_prev_q;
    if (EDGE_TYPE == 0) begin
      edge_hit = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = fall;
    end else begin
      edge_hit = rise | fall;
    end

    wr_en     = bus.chipselect & ~bus.write_n;
    irqmask_d = irqmask_q;
    ec_clr    = '0;
    if (wr_en && bus.address == 2'd2) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && bus.address == 2'd3) begin
      ec_clr = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~ec_clr) | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= IN_RESET;
      sync2_q    <= IN_RESET;
      deb_q      <= IN_RESET;
      deb_prev_q <= IN_RESET;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read path has no side effects and does not depend on chipselect.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = deb_q;
      2'd2:    bus.readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    bus.readdata[WIDTH-1:0] = edgecap_q;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_model_keys_in.sv
// tb_model_keys_in: directed bench for model_keys_in with WIDTH=4,
// DEBOUNCE_CYCLES=4, EDGE_TYPE=1 (falling). Inputs change just after the
// falling clock edge; outputs are sampled shortly after the falling edge.
`timescale 1ns/1ps
module tb_model_keys_in;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [31:0] rdv;

  model_keys_in_if bus_if ();

  model_keys_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IN_RESET(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if.slave), .in_port(in_port), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = '0;
    cyc(3);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL rst_data: got %h want %h", rdv, 32'hF); end
    rd(2'd1, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_addr1: got %h want %h", rdv, 32'h0); end
    rd(2'd2, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_mask: got %h want %h", rdv, 32'h0); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_ec: got %h want %h", rdv, 32'h0); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(10);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL post_rst_ec: got %h want %h", rdv, 32'h0); end
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL post_rst_data: got %h want %h", rdv, 32'hF); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL post_rst_irq: got %b want 0", irq); end
  endtask

  task automatic test_debounce;
    @(negedge clk);
    in_port = 4'hE;
    cyc(5);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL deb_early: got %h want %h", rdv, 32'hF); end
    cyc(1);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hE) begin n_fail++; $display("FAIL deb_at6: got %h want %h", rdv, 32'hE); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL ec_at6: got %h want %h", rdv, 32'h0); end
    cyc(1);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h1) begin n_fail++; $display("FAIL ec_at7: got %h want %h", rdv, 32'h1); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_irq;
    wr(2'd2, 32'h1);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask: got %b want 1", irq); end
    rd(2'd2, rdv); n_tests++;
    if (rdv !== 32'h1) begin n_fail++; $display("FAIL mask_read: got %h want %h", rdv, 32'h1); end
    wr(2'd0, 32'h0);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hE) begin n_fail++; $display("FAIL data_ro: got %h want %h", rdv, 32'hE); end
    wr(2'd1, 32'hF);
    rd(2'd1, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL addr1_ro: got %h want %h", rdv, 32'h0); end
    wr(2'd3, 32'h1);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL ec_clear: got %h want %h", rdv, 32'h0); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      in_port = 4'hC;
      cyc(2);
      @(negedge clk);
      in_port = 4'hE;
      cyc(1);
    end
    cyc(8);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hE) begin n_fail++; $display("FAIL bounce_data: got %h want %h", rdv, 32'hE); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL bounce_ec: got %h want %h", rdv, 32'h0); end
    @(negedge clk);
    in_port = 4'hC;
    cyc(3);
    @(negedge clk);
    in_port = 4'hE;
    cyc(2);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hC) begin n_fail++; $display("FAIL hold4_data: got %h want %h", rdv, 32'hC); end
    cyc(10);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h2) begin n_fail++; $display("FAIL hold4_ec: got %h want %h", rdv, 32'h2); end
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hE) begin n_fail++; $display("FAIL release_data: got %h want %h", rdv, 32'hE); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL hold4_irq: got %b want 0", irq); end
    wr(2'd3, 32'h2);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL bit1_clear: got %h want %h", rdv, 32'h0); end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    in_port = 4'hA;
    cyc(5);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hE) begin n_fail++; $display("FAIL sim_data5: got %h want %h", rdv, 32'hE); end
    cyc(1);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hA) begin n_fail++; $display("FAIL sim_data6: got %h want %h", rdv, 32'hA); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL sim_ec6: got %h want %h", rdv, 32'h0); end
    // Clear of bit 2 lands on the same edge that captures its falling edge.
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = 2'd3;
    bus_if.writedata  = 32'h4;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h4) begin n_fail++; $display("FAIL set_wins: got %h want %h", rdv, 32'h4); end
    wr(2'd3, 32'h0);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h4) begin n_fail++; $display("FAIL w0_noclear: got %h want %h", rdv, 32'h4); end
    wr(2'd2, 32'h4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_bit2: got %b want 1", irq); end
    wr(2'd3, 32'h4);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL bit2_clear: got %h want %h", rdv, 32'h0); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_bit2_clear: got %b want 0", irq); end
  endtask

  task automatic test_multi_bit;
    @(negedge clk);
    in_port = 4'hF;
    cyc(10);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL rise_data: got %h want %h", rdv, 32'hF); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL rise_ignored: got %h want %h", rdv, 32'h0); end
    @(negedge clk);
    in_port = 4'h5;
    cyc(6);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'h5) begin n_fail++; $display("FAIL multi_data: got %h want %h", rdv, 32'h5); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL multi_ec6: got %h want %h", rdv, 32'h0); end
    cyc(1);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'hA) begin n_fail++; $display("FAIL multi_ec7: got %h want %h", rdv, 32'hA); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL multi_irq: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid;
    wr(2'd2, 32'hF);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    @(negedge clk);
    in_port = 4'h4;
    cyc(4);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL mid_rst_data: got %h want %h", rdv, 32'hF); end
    rd(2'd2, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mask: got %h want %h", rdv, 32'h0); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ec: got %h want %h", rdv, 32'h0); end
    cyc(2);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(5);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'hF) begin n_fail++; $display("FAIL restart_early: got %h want %h", rdv, 32'hF); end
    cyc(1);
    rd(2'd0, rdv); n_tests++;
    if (rdv !== 32'h4) begin n_fail++; $display("FAIL restart_data: got %h want %h", rdv, 32'h4); end
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'h0) begin n_fail++; $display("FAIL restart_ec6: got %h want %h", rdv, 32'h0); end
    cyc(1);
    rd(2'd3, rdv); n_tests++;
    if (rdv !== 32'hB) begin n_fail++; $display("FAIL restart_ec7: got %h want %h", rdv, 32'hB); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL restart_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_bounce();
    test_simultaneous();
    test_multi_bit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/model_keys_in.md
# model_keys_in

Avalon-MM slave input port for debounced push-buttons and switches, mirroring the LED output port on the same system interconnect. Two-flop synchronises each external input, debounces each bit with its own counter, and exposes the stable level. Latches qualifying edges in a sticky edge-capture register and raises a maskable level interrupt to the processor. Register map is PIO-compatible, so the existing driver code reads it unchanged.

## Interface

- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised bit must differ from the debounced level before it is accepted (≥2); 1 ms at 50 MHz
- EDGE_TYPE, 1, capture on 0 = rising, 1 = falling, 2 = any edge of the debounced level
- IN_RESET, {WIDTH{1'b1}}, value loaded into the synchroniser and debounced registers at reset (keys idle high)

- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- address, in, 2, register select
- chipselect, in, 1, slave select
- write_n, in, 1, active-low write strobe
- writedata, in, 32, write data
- in_port, in, WIDTH, raw asynchronous external inputs
- readdata, out, 32, read data, zero-extended above WIDTH
- irq, out, 1, level interrupt, active high

## Operation

- Register map (word addresses):
  - 0 data: debounced level, read-only; writes ignored.
  - 1: reads 0, writes ignored.
  - 2 irqmask: read/write, bits [WIDTH-1:0].
  - 3 edgecapture: read; write-1-to-clear per bit (writedata bit = 1 clears that bit, 0 leaves it).
- Write occurs when chipselect && !write_n; no wait states.
- Read path combinational from address: readdata = selected register, zero-extended; chipselect not required for readdata; no read side effects.
- Synchroniser: sync1 <= in_port; sync2 <= sync1, per bit.
- Debounce, per bit i, counter width clog2(DEBOUNCE_CYCLES):
  - sync2[i] == deb[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i], cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i] + 1.
  - Any bounce back to deb[i] before terminal count restarts the count from 0.
- Edge detect: deb_d <= deb.
  - rise = deb & ~deb_d; fall = ~deb & deb_d.
  - Qualifying edge selected by EDGE_TYPE.
- Edgecapture, per bit:
  - Set on a qualifying edge.
  - Cleared by a write of 1 to address 3.
  - Simultaneous edge and clear: set wins.
  - Otherwise holds.
- irq = |(edgecapture & irqmask), combinational from registers.

## Timing

- Reset values:
  - sync1, sync2, deb, deb_d = IN_RESET.
  - cnt, irqmask, edgecapture = 0.
  - irq = 0; readdata at address 0 = IN_RESET.
  - No edges are detected out of reset.
- in_port change at cycle 0 (setup met): sync2 changes at edge 2; deb changes at edge 2+DEBOUNCE_CYCLES; edgecapture sets and irq asserts one cycle later.
- irqmask write is visible on readdata and irq the cycle after the write edge.
- An edgecapture clear deasserts irq the cycle after the write.
- reset_n assertion mid-count or mid-write forces all registers to reset values immediately (asynchronous); release is synchronous to clk via the system reset synchroniser.
- Bits are fully independent; simultaneous edges on several bits all capture in the same cycle.

## Test plan

Benches use DEBOUNCE_CYCLES = 4, WIDTH = 4, EDGE_TYPE = 1.

- Reset with in_port = 4'hF -> read addr 0 = 0xF, addr 2 = 0, addr 3 = 0, irq = 0; no capture after reset release.
- Drive in_port[0] = 0 and hold -> addr 0 reads 0xE exactly 6 cycles later; edgecapture = 0x1 at cycle 7; irq stays 0 with mask 0.
- Write irqmask = 0x1 -> irq = 1 next cycle. Write 0x1 to addr 3 -> edgecapture = 0, irq = 0 next cycle.
- Bounce: toggle in_port[1] low for 3 cycles, then high, repeated -> deb[1] never changes and edgecapture stays 0. Then hold low 4 cycles -> capture bit 1.
- Simultaneous: a write-1 clear of bit 2 in the same cycle as a new falling edge on bit 2 -> edgecapture[2] = 1 after the cycle. Write 0x0 to addr 3 -> no bits clear.
- Assert reset_n mid-debounce with cnt = 2 and mask = 0xF -> all registers at reset values immediately, irq = 0; the count restarts from 0 after release.
